rv32_operand_fwd: RTL and testbench
===================================

Name: rv32_operand_fwd

Overview:
- Decode→execute operand stage directly downstream of the register file.
- Takes the decode instruction's rs1/rs2 indices and raw register-file read values.
- Applies bypassing from the execute, mem and writeback stages, and detects load-use hazards (stall plus bubble).
- Registers the resolved operands into the execute pipeline register.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 16, width of the load-use stall event counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall_in  in  1  downstream stall; holds the output register.
- flush_in  in  1  execute flush; next output is a bubble.
- valid_in  in  1  decode holds a valid instruction.
- rs1_in  in  5  decode rs1 index.
- rs2_in  in  5  decode rs2 index.
- rs1_value_in  in  XLEN  register-file read data for rs1_in.
- rs2_value_in  in  XLEN  register-file read data for rs2_in.
- ex_rd_in  in  5  execute-stage destination.
- ex_rd_write_in  in  1  execute writes rd.
- ex_load_in  in  1  execute instruction is a load; its result is not yet available.
- ex_result_in  in  XLEN  execute ALU result.
- mem_rd_in  in  5  mem-stage destination.
- mem_rd_write_in  in  1  mem writes rd.
- mem_result_in  in  XLEN  mem result, including load data.
- wb_rd_in  in  5  writeback destination.
- wb_rd_write_in  in  1  writeback writes rd.
- wb_flush_in  in  1  writeback flushed.
- wb_value_in  in  XLEN  writeback value.
- stall_out  out  1  load-use stall request to fetch/decode/regfile.
- valid_out  out  1  execute operands valid.
- rs1_out  out  5  registered rs1 index.
- rs2_out  out  5  registered rs2 index.
- rs1_value_out  out  XLEN  registered resolved rs1 operand.
- rs2_value_out  out  XLEN  registered resolved rs2 operand.
- stall_count_out  out  CNT_W  count of load-use stall cycles.

Behaviour:
- Reset (async on reset_n low) clears valid_out, rs1_out, rs2_out, rs1_value_out, rs2_value_out and stall_count_out to 0. stall_out is 0 while in reset.
- Operand resolution is combinational and evaluated per source (rs1, rs2) independently. Priority is:
  1. Index 0 → 0.
  2. ex match: ex_rd_write_in and ex_rd_in == index and !ex_load_in → ex_result_in.
  3. mem match: mem_rd_write_in and mem_rd_in == index → mem_result_in.
  4. wb match: wb_rd_write_in, !wb_flush_in and wb_rd_in == index → wb_value_in. This covers the same-cycle regfile write not yet visible on the read port.
  5. Otherwise the regfile value.
- A matching ex_rd_in with rd 0 never forwards.
- load_use = valid_in and ex_load_in and ex_rd_write_in and ex_rd_in != 0 and (ex_rd_in == rs1_in or ex_rd_in == rs2_in).
- stall_out = load_use and !flush_in. stall_out is combinational, same cycle.
- Output register update on clk rising edge, in priority order:
  - flush_in=1: valid_out←0. Flush overrides stall_in and load_use.
  - else stall_in=1: all outputs hold.
  - else load_use: valid_out←0 (bubble); index/value outputs unchanged.
  - else: valid_out←valid_in; rs1_out/rs2_out←indices; values←resolved operands.
- Latency is one cycle from decode to execute. A load-use hazard costs exactly one bubble: the next cycle the load is in mem and is forwarded from mem_result_in.
- stall_count_out increments by 1 on each edge where stall_out=1 and stall_in=0. It saturates at all-ones and does not wrap.
- While stall_in=1, stall_out may still assert, but the counter does not advance.
- Reset asserted mid-stall clears everything immediately. After deassertion the first edge behaves as the normal case.

Test Plan:
- Reset: reset_n=0 with all inputs random → all outputs 0, stall_out=0. Release, valid_in=1, rs1=3/rs2=4, regfile values 0x11/0x22, no matches → next edge valid_out=1, values 0x11/0x22.
- Priority: rs1=5 with ex (rd=5, 0xAAAA), mem (rd=5, 0xBBBB) and wb (rd=5, 0xCCCC) all writing → rs1_value_out=0xAAAA. Drop ex → 0xBBBB. Drop mem → 0xCCCC. Set wb_flush_in → regfile value.
- x0: rs1=0, ex writes rd=0 with 0xDEAD → rs1_value_out=0, no stall.
- Load-use: ex_load_in=1, ex_rd=7, rs2=7 → stall_out=1, next edge valid_out=0, stall_count=1. Next cycle mem_rd=7, mem_result 0x1234, load gone → rs2_value_out=0x1234, valid_out=1.
- Flush vs stall: stall_in=1 and flush_in=1 together → valid_out=0. stall_in=1 alone for 3 cycles → outputs held bit-exact.
- Counter saturation: CNT_W=2, 5 consecutive load-use cycles → stall_count_out sequence 1,2,3,3,3.

Source files
------------

// File: rtl/rv32_operand_fwd.sv
// Decode-to-execute operand stage: bypasses ex/mem/wb results onto the register-file
// read data, detects load-use hazards, and registers the resolved operands for execute.
module rv32_operand_fwd #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic             valid_in,
  input  logic [4:0]       rs1_in,
  input  logic [4:0]       rs2_in,
  input  logic [XLEN-1:0]  rs1_value_in,
  input  logic [XLEN-1:0]  rs2_value_in,
  input  logic [4:0]       ex_rd_in,
  input  logic             ex_rd_write_in,
  input  logic             ex_load_in,
  input  logic [XLEN-1:0]  ex_result_in,
  input  logic [4:0]       mem_rd_in,
  input  logic             mem_rd_write_in,
  input  logic [XLEN-1:0]  mem_result_in,
  input  logic [4:0]       wb_rd_in,
  input  logic             wb_rd_write_in,
  input  logic             wb_flush_in,
  input  logic [XLEN-1:0]  wb_value_in,
  output logic             stall_out,
  output logic             valid_out,
  output logic [4:0]       rs1_out,
  output logic [4:0]       rs2_out,
  output logic [XLEN-1:0]  rs1_value_out,
  output logic [XLEN-1:0]  rs2_value_out,
  output logic [CNT_W-1:0] stall_count_out
);

  logic             load_use_p0;
  logic [XLEN-1:0]  rs1_res_p0;
  logic [XLEN-1:0]  rs2_res_p0;
  logic             vld_p1;
  logic [4:0]       rs1_idx_p1;
  logic [4:0]       rs2_idx_p1;
  logic [XLEN-1:0]  rs1_val_p1;
  logic [XLEN-1:0]  rs2_val_p1;
  logic [CNT_W-1:0] stall_cnt_p1;

  // Youngest producer wins; a load in execute has no data yet, so it is skipped here
  // and covered by the load-use stall instead.
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_val,
    input logic [4:0]      ex_rd,
    input logic            ex_wr,
    input logic            ex_ld,
    input logic [XLEN-1:0] ex_val,
    input logic [4:0]      mem_rd,
    input logic            mem_wr,
    input logic [XLEN-1:0] mem_val,
    input logic [4:0]      wb_rd,
    input logic            wb_wr,
    input logic            wb_fl,
    input logic [XLEN-1:0] wb_val
  );
    if (idx == 5'd0)                           return '0;
    else if (ex_wr && !ex_ld && ex_rd == idx)  return ex_val;
    else if (mem_wr && mem_rd == idx)          return mem_val;
    else if (wb_wr && !wb_fl && wb_rd == idx)  return wb_val;
    else                                       return rf_val;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) return cnt;
    else      return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: combinational operand resolution and hazard detection
  always_comb begin
    rs1_res_p0 = resolve_operand(rs1_in, rs1_value_in, ex_rd_in, ex_rd_write_in, ex_load_in,
                                 ex_result_in, mem_rd_in, mem_rd_write_in, mem_result_in,
                                 wb_rd_in, wb_rd_write_in, wb_flush_in, wb_value_in);
    rs2_res_p0 = resolve_operand(rs2_in, rs2_value_in, ex_rd_in, ex_rd_write_in, ex_load_in,
                                 ex_result_in, mem_rd_in, mem_rd_write_in, mem_result_in,
                                 wb_rd_in, wb_rd_write_in, wb_flush_in, wb_value_in);
    load_use_p0 = valid_in && ex_load_in && ex_rd_write_in && (ex_rd_in != 5'd0) &&
                  ((ex_rd_in == rs1_in) || (ex_rd_in == rs2_in));
  end

  // Gated by reset_n so random inputs during reset never raise a stall request.
  assign stall_out = load_use_p0 && !flush_in && reset_n;

  // Stage p1: execute pipeline register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      rs1_idx_p1 <= '0;
      rs2_idx_p1 <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
    end else if (flush_in) begin
      vld_p1 <= 1'b0;
    end else if (stall_in) begin
      vld_p1 <= vld_p1;
    end else if (load_use_p0) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1     <= valid_in;
      rs1_idx_p1 <= rs1_in;
      rs2_idx_p1 <= rs2_in;
      rs1_val_p1 <= rs1_res_p0;
      rs2_val_p1 <= rs2_res_p0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    stall_cnt_p1 <= '0;
    else if (stall_out && !stall_in) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
  end

  assign valid_out       = vld_p1;
  assign rs1_out         = rs1_idx_p1;
  assign rs2_out         = rs2_idx_p1;
  assign rs1_value_out   = rs1_val_p1;
  assign rs2_value_out   = rs2_val_p1;
  assign stall_count_out = stall_cnt_p1;

endmodule

// File: tb/tb_rv32_operand_fwd.sv
// Directed bench for rv32_operand_fwd: forwarding priority, x0, load-use bubble,
// flush/stall interaction and saturating stall counter (CNT_W=2).
module tb_rv32_operand_fwd;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             stall_in, flush_in, valid_in;
  logic [4:0]       rs1_in, rs2_in;
  logic [XLEN-1:0]  rs1_value_in, rs2_value_in;
  logic [4:0]       ex_rd_in;
  logic             ex_rd_write_in, ex_load_in;
  logic [XLEN-1:0]  ex_result_in;
  logic [4:0]       mem_rd_in;
  logic             mem_rd_write_in;
  logic [XLEN-1:0]  mem_result_in;
  logic [4:0]       wb_rd_in;
  logic             wb_rd_write_in, wb_flush_in;
  logic [XLEN-1:0]  wb_value_in;
  logic             stall_out, valid_out;
  logic [4:0]       rs1_out, rs2_out;
  logic [XLEN-1:0]  rs1_value_out, rs2_value_out;
  logic [CNT_W-1:0] stall_count_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32_operand_fwd #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in),
    .ex_rd_in(ex_rd_in), .ex_rd_write_in(ex_rd_write_in), .ex_load_in(ex_load_in),
    .ex_result_in(ex_result_in), .mem_rd_in(mem_rd_in), .mem_rd_write_in(mem_rd_write_in),
    .mem_result_in(mem_result_in), .wb_rd_in(wb_rd_in), .wb_rd_write_in(wb_rd_write_in),
    .wb_flush_in(wb_flush_in), .wb_value_in(wb_value_in), .stall_out(stall_out),
    .valid_out(valid_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .rs1_value_out(rs1_value_out), .rs2_value_out(rs2_value_out),
    .stall_count_out(stall_count_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_in = 0; flush_in = 0; valid_in = 0;
    rs1_in = 0; rs2_in = 0; rs1_value_in = 0; rs2_value_in = 0;
    ex_rd_in = 0; ex_rd_write_in = 0; ex_load_in = 0; ex_result_in = 0;
    mem_rd_in = 0; mem_rd_write_in = 0; mem_result_in = 0;
    wb_rd_in = 0; wb_rd_write_in = 0; wb_flush_in = 0; wb_value_in = 0;
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_valid"}, {31'b0, valid_out}, 32'h1);
    chk({tag, "_rs1"},   {27'b0, rs1_out},   32'd2);
    chk({tag, "_rs2"},   {27'b0, rs2_out},   32'd6);
    chk({tag, "_rs1v"},  rs1_value_out,      32'h2222);
    chk({tag, "_rs2v"},  rs2_value_out,      32'h6666);
    chk({tag, "_cnt"},   {30'b0, stall_count_out}, 32'd1);
  endtask

  initial begin
    // Reset with random inputs
    reset_n = 0;
    stall_in = 1'($urandom); flush_in = 1'($urandom); valid_in = 1'b1;
    rs1_in = 5'd7; rs2_in = 5'($urandom); rs1_value_in = $urandom; rs2_value_in = $urandom;
    ex_rd_in = 5'd7; ex_rd_write_in = 1; ex_load_in = 1; ex_result_in = $urandom;
    mem_rd_in = 5'($urandom); mem_rd_write_in = 1'($urandom); mem_result_in = $urandom;
    wb_rd_in = 5'($urandom); wb_rd_write_in = 1'($urandom); wb_flush_in = 1'($urandom);
    wb_value_in = $urandom;
    #2;
    step(); step();
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_rs1", {27'b0, rs1_out}, 32'h0);
    chk("rst_rs2", {27'b0, rs2_out}, 32'h0);
    chk("rst_rs1v", rs1_value_out, 32'h0);
    chk("rst_rs2v", rs2_value_out, 32'h0);
    chk("rst_cnt", {30'b0, stall_count_out}, 32'h0);
    chk("rst_stall", {31'b0, stall_out}, 32'h0);

    clear_inputs();
    reset_n = 1;
    valid_in = 1; rs1_in = 3; rs2_in = 4; rs1_value_in = 32'h11; rs2_value_in = 32'h22;
    step();
    chk("first_valid", {31'b0, valid_out}, 32'h1);
    chk("first_rs1", {27'b0, rs1_out}, 32'd3);
    chk("first_rs2", {27'b0, rs2_out}, 32'd4);
    chk("first_rs1v", rs1_value_out, 32'h11);
    chk("first_rs2v", rs2_value_out, 32'h22);

    // Forwarding priority ex > mem > wb > regfile
    rs1_in = 5; rs1_value_in = 32'h5555;
    ex_rd_in = 5; ex_rd_write_in = 1; ex_result_in = 32'hAAAA;
    mem_rd_in = 5; mem_rd_write_in = 1; mem_result_in = 32'hBBBB;
    wb_rd_in = 5; wb_rd_write_in = 1; wb_value_in = 32'hCCCC;
    step();
    chk("prio_ex", rs1_value_out, 32'hAAAA);
    chk("prio_ex_rs2", rs2_value_out, 32'h22);
    ex_rd_write_in = 0;
    step();
    chk("prio_mem", rs1_value_out, 32'hBBBB);
    mem_rd_write_in = 0;
    step();
    chk("prio_wb", rs1_value_out, 32'hCCCC);
    wb_flush_in = 1;
    step();
    chk("prio_wbflush", rs1_value_out, 32'h5555);
    wb_flush_in = 0; wb_rd_write_in = 0;

    // x0 never forwards, never stalls
    rs1_in = 0; rs1_value_in = 32'h999;
    ex_rd_in = 0; ex_rd_write_in = 1; ex_result_in = 32'hDEAD;
    #1;
    chk("x0_nostall", {31'b0, stall_out}, 32'h0);
    step();
    chk("x0_value", rs1_value_out, 32'h0);
    chk("x0_valid", {31'b0, valid_out}, 32'h1);
    ex_load_in = 1;
    #1;
    chk("x0_load_nostall", {31'b0, stall_out}, 32'h0);
    ex_load_in = 0; ex_rd_write_in = 0;

    // Load-use: one bubble, then mem forwarding
    rs1_in = 1; rs1_value_in = 32'h100; rs2_in = 7; rs2_value_in = 32'h77;
    ex_rd_in = 7; ex_rd_write_in = 1; ex_load_in = 1; ex_result_in = 32'hFFFF;
    #1;
    chk("lu_stall", {31'b0, stall_out}, 32'h1);
    step();
    chk("lu_bubble", {31'b0, valid_out}, 32'h0);
    chk("lu_cnt", {30'b0, stall_count_out}, 32'd1);
    chk("lu_rs2v_hold", rs2_value_out, 32'h22);
    chk("lu_rs1_hold", {27'b0, rs1_out}, 32'd0);
    ex_rd_write_in = 0; ex_load_in = 0;
    mem_rd_in = 7; mem_rd_write_in = 1; mem_result_in = 32'h1234;
    #1;
    chk("lu_release", {31'b0, stall_out}, 32'h0);
    step();
    chk("lu_fwd_rs2v", rs2_value_out, 32'h1234);
    chk("lu_fwd_rs1v", rs1_value_out, 32'h100);
    chk("lu_fwd_valid", {31'b0, valid_out}, 32'h1);
    chk("lu_fwd_cnt", {30'b0, stall_count_out}, 32'd1);
    mem_rd_write_in = 0;

    // Load a known state, then hold it under stall_in for 3 cycles
    rs1_in = 2; rs2_in = 6; rs1_value_in = 32'h2222; rs2_value_in = 32'h6666;
    step();
    check_held("load");
    stall_in = 1;
    rs1_in = 9; rs2_in = 10; rs1_value_in = 32'hA9; rs2_value_in = 32'hA10;
    ex_rd_in = 9; ex_rd_write_in = 1; ex_load_in = 1;
    #1;
    chk("hold_stallout", {31'b0, stall_out}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_held($sformatf("hold%0d", i));
    end

    // Flush overrides stall_in and load-use
    flush_in = 1;
    #1;
    chk("flush_nostall", {31'b0, stall_out}, 32'h0);
    step();
    chk("flush_valid", {31'b0, valid_out}, 32'h0);
    chk("flush_cnt", {30'b0, stall_count_out}, 32'd1);

    // Reset asserted mid-stall clears immediately
    flush_in = 0; stall_in = 0;
    #1;
    reset_n = 0;
    #1;
    chk("midrst_cnt", {30'b0, stall_count_out}, 32'd0);
    chk("midrst_stall", {31'b0, stall_out}, 32'h0);
    chk("midrst_rs1v", rs1_value_out, 32'h0);
    step();
    reset_n = 1;
    ex_load_in = 0; ex_rd_write_in = 0;
    rs1_in = 3; rs2_in = 4; rs1_value_in = 32'h33; rs2_value_in = 32'h44;
    step();
    chk("postrst_valid", {31'b0, valid_out}, 32'h1);
    chk("postrst_rs1v", rs1_value_out, 32'h33);
    chk("postrst_rs2v", rs2_value_out, 32'h44);

    // Counter saturation at 2'b11
    ex_rd_in = 4; ex_rd_write_in = 1; ex_load_in = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sat_cnt%0d", i), {30'b0, stall_count_out}, (i < 3) ? i + 1 : 3);
      chk($sformatf("sat_valid%0d", i), {31'b0, valid_out}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
